game_sequencer: RTL and testbench

Parametrised game-flow controller for the arcade top level. It replaces the free-running toggled physics clock with a proper one-cycle tick strobe and owns the game state machine (idle/playing/paused/over), score, lives and world-reset sequencing. Doodle, block and view managers consume its strobes; the renderer consumes score and state.

---
 rtl/game_pkg.sv | 16 +
 rtl/game_sequencer_rise_edge.sv | 19 +
 rtl/game_sequencer.sv | 121 ++++++++++++
 tb/tb_game_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-flow types and screen/block geometry for the arcade top level.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        PAUSED  = 2'd2,
        OVER    = 2'd3
    } state_t;

    localparam int SCR_W = 30;
    localparam int SCR_H = 30;
    localparam int BLK_W = 3;
    localparam int BLK_H = 2;

endpackage

// File: rtl/game_sequencer_rise_edge.sv
// Rising-edge detector for a level button; the history register resets to 1
// so a button held through reset produces no pulse.
module rise_edge (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk) begin
        if (reset) prev <= 1'b1;
        else       prev <= in;
    end

    assign pulse = in & ~prev;

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: physics tick strobe, idle/playing/paused/over FSM,
// score, lives and world-reset sequencing. All outputs registered.
module game_sequencer
    import game_pkg::*;
#(
    parameter int TICK_DIV   = 4,
    parameter int SCORE_W    = 16,
    parameter int LIVES      = 3,
    parameter int LIVES_W    = 2,
    parameter int SCROLL_PTS = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_btn,
    input  logic               pause_btn,
    input  logic               left_btn,
    input  logic               right_btn,
    input  logic               new_view,
    input  logic               fell,
    output logic               phys_tick,
    output logic               move_left,
    output logic               move_right,
    output logic               world_reset,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] score,
    output logic [LIVES_W-1:0] lives
);

    localparam int                CNT_W = $clog2(TICK_DIV + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [SCORE_W:0]  PTS = (SCORE_W + 1)'(SCROLL_PTS);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic             sticky_l, sticky_r;
    logic             start_edge, pause_edge;

    logic             playing, start_game, lose_life, last_life, go_pause;
    logic             issue_wr, count_en, wrap;
    logic             nxt_l, nxt_r;
    logic [SCORE_W:0] score_sum;

    rise_edge u_start (.clk(clk), .reset(reset), .in(start_btn), .pulse(start_edge));
    rise_edge u_pause (.clk(clk), .reset(reset), .in(pause_btn), .pulse(pause_edge));

    assign playing    = (st == PLAYING);
    assign start_game = ((st == IDLE) || (st == OVER)) && start_edge;
    assign lose_life  = playing && fell && (lives > LIVES_W'(1));
    assign last_life  = playing && fell && (lives <= LIVES_W'(1));
    assign go_pause   = playing && !fell && pause_edge;
    assign issue_wr   = start_game || lose_life;
    assign count_en   = playing && !issue_wr;
    assign wrap       = (cnt == CNT_LAST);
    assign score_sum  = {1'b0, score} + PTS;

    // The tick cycle itself opens the next interval, so its presses restart the sticky bits.
    assign nxt_l = phys_tick ? left_btn  : (sticky_l | left_btn);
    assign nxt_r = phys_tick ? right_btn : (sticky_r | right_btn);

    assign state = st;

    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= IDLE;
            score       <= '0;
            lives       <= '0;
            cnt         <= '0;
            sticky_l    <= 1'b0;
            sticky_r    <= 1'b0;
            phys_tick   <= 1'b0;
            move_left   <= 1'b0;
            move_right  <= 1'b0;
            world_reset <= 1'b0;
        end else begin
            world_reset <= issue_wr;
            phys_tick   <= 1'b0;
            move_left   <= 1'b0;
            move_right  <= 1'b0;

            if (issue_wr) begin
                cnt      <= '0;
                sticky_l <= 1'b0;
                sticky_r <= 1'b0;
            end else if (count_en) begin
                sticky_l <= nxt_l;
                sticky_r <= nxt_r;
                if (wrap) begin
                    cnt <= '0;
                    if (!go_pause) begin
                        phys_tick  <= 1'b1;
                        move_left  <= nxt_l & ~nxt_r;
                        move_right <= nxt_r & ~nxt_l;
                    end
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end

            if (start_game) begin
                st    <= PLAYING;
                score <= '0;
                lives <= LIVES_INIT;
            end else if (playing) begin
                if (new_view)
                    score <= score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
                if (lose_life) begin
                    lives <= lives - LIVES_W'(1);
                end else if (last_life) begin
                    st    <= OVER;
                    lives <= '0;
                end else if (go_pause) begin
                    st <= PAUSED;
                end
            end else if ((st == PAUSED) && pause_edge) begin
                st <= PLAYING;
            end
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench: three sequencer instances (default, TICK_DIV=1, SCORE_W=4)
// share one stimulus stream; expected values are hand-derived cycle by cycle.
module tb_game_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start_btn, pause_btn, left_btn, right_btn, new_view, fell;

    logic        a_tick, a_ml, a_mr, a_wr;
    logic [1:0]  a_state;
    logic [15:0] a_score;
    logic [1:0]  a_lives;

    logic        b_tick, b_ml, b_mr, b_wr;
    logic [1:0]  b_state;
    logic [15:0] b_score;
    logic [1:0]  b_lives;

    logic        c_tick, c_ml, c_mr, c_wr;
    logic [1:0]  c_state;
    logic [3:0]  c_score;
    logic [1:0]  c_lives;

    game_sequencer dut (
        .clk(clk), .reset(reset), .start_btn(start_btn), .pause_btn(pause_btn),
        .left_btn(left_btn), .right_btn(right_btn), .new_view(new_view), .fell(fell),
        .phys_tick(a_tick), .move_left(a_ml), .move_right(a_mr), .world_reset(a_wr),
        .state(a_state), .score(a_score), .lives(a_lives)
    );

    game_sequencer #(.TICK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .start_btn(start_btn), .pause_btn(pause_btn),
        .left_btn(left_btn), .right_btn(right_btn), .new_view(new_view), .fell(fell),
        .phys_tick(b_tick), .move_left(b_ml), .move_right(b_mr), .world_reset(b_wr),
        .state(b_state), .score(b_score), .lives(b_lives)
    );

    game_sequencer #(.SCORE_W(4)) dut_s (
        .clk(clk), .reset(reset), .start_btn(start_btn), .pause_btn(pause_btn),
        .left_btn(left_btn), .right_btn(right_btn), .new_view(new_view), .fell(fell),
        .phys_tick(c_tick), .move_left(c_ml), .move_right(c_mr), .world_reset(c_wr),
        .state(c_state), .score(c_score), .lives(c_lives)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start_btn = 1'b1; pause_btn = 1'b0; left_btn = 1'b0;
        right_btn = 1'b0; new_view = 1'b0; fell = 1'b0;
        step(3);
        chk("rst_state", 32'(a_state), 0);
        chk("rst_score", 32'(a_score), 0);
        chk("rst_lives", 32'(a_lives), 0);
        chk("rst_tick",  32'(a_tick), 0);
        chk("rst_wr",    32'(a_wr), 0);
        chk("rst_move",  32'({a_ml, a_mr}), 0);

        // start held through reset and beyond must not start a game
        reset = 1'b0;
        step(5);
        chk("held_start_state", 32'(a_state), 0);
        chk("held_start_wr",    32'(a_wr), 0);

        start_btn = 1'b0; step(1);
        start_btn = 1'b1; step(1);  // cycle W
        chk("start_state", 32'(a_state), 1);
        chk("start_wr",    32'(a_wr), 1);
        chk("start_lives", 32'(a_lives), 3);
        chk("start_score", 32'(a_score), 0);
        chk("div1_wr_tick", 32'(b_tick), 0);
        start_btn = 1'b0;

        for (int i = 1; i <= 20; i++) begin
            step(1);
            chk("tick_div4", 32'(a_tick), 32'(i % 4 == 0));
            chk("tick_div1", 32'(b_tick), 1);
            chk("wr_one_cycle", 32'(a_wr), 0);
        end

        step(1);                    // W+21
        left_btn = 1'b1; step(1);
        left_btn = 1'b0; step(2);   // W+24
        chk("left_tick", 32'(a_tick), 1);
        chk("left_ml",   32'(a_ml), 1);
        chk("left_mr",   32'(a_mr), 0);
        step(4);                    // W+28
        chk("left_clr_tick", 32'(a_tick), 1);
        chk("left_clr_ml",   32'(a_ml), 0);

        step(1);
        left_btn = 1'b1; step(1);
        left_btn = 1'b0; right_btn = 1'b1; step(1);
        right_btn = 1'b0; step(1);  // W+32
        chk("both_tick", 32'(a_tick), 1);
        chk("both_move", 32'({a_ml, a_mr}), 0);

        right_btn = 1'b1; step(1);  // press in tick cycle carries over
        right_btn = 1'b0; step(3);  // W+36
        chk("carry_tick", 32'(a_tick), 1);
        chk("carry_mr",   32'(a_mr), 1);
        chk("carry_ml",   32'(a_ml), 0);

        step(1);                    // W+37, second PLAYING cycle of interval
        pause_btn = 1'b1; step(1);
        pause_btn = 1'b0;           // W+38
        chk("pause_state", 32'(a_state), 2);
        chk("pause_tick",  32'(a_tick), 0);
        for (int i = 0; i < 9; i++) begin
            step(1);
            chk("paused_state", 32'(a_state), 2);
            chk("paused_tick",  32'({a_tick, b_tick}), 0);
        end
        pause_btn = 1'b1; step(1);  // W+48
        pause_btn = 1'b0;
        chk("resume_state", 32'(a_state), 1);
        chk("resume_wr",    32'(a_wr), 0);
        chk("resume_tick0", 32'(a_tick), 0);
        step(1);
        chk("resume_tick1", 32'(a_tick), 0);
        step(1);
        chk("resume_tick2", 32'(a_tick), 1);

        new_view = 1'b1; step(1);
        new_view = 1'b0;
        chk("score1",     32'(a_score), 10);
        chk("score1_sat", 32'(c_score), 10);
        new_view = 1'b1; step(1);
        new_view = 1'b0;
        chk("score2",     32'(a_score), 20);
        chk("score2_sat", 32'(c_score), 15);

        fell = 1'b1; step(1);
        fell = 1'b0;
        chk("fell3_lives", 32'(a_lives), 2);
        chk("fell3_wr",    32'(a_wr), 1);
        chk("fell3_state", 32'(a_state), 1);
        chk("fell3_score", 32'(a_score), 20);
        chk("fell3_div1_tick", 32'(b_tick), 0);

        fell = 1'b1; pause_btn = 1'b1; step(1);
        fell = 1'b0; pause_btn = 1'b0;
        chk("fell_pause_lives", 32'(a_lives), 1);
        chk("fell_pause_state", 32'(a_state), 1);
        chk("fell_pause_wr",    32'(a_wr), 1);

        step(1);
        fell = 1'b1; step(1);
        fell = 1'b0;
        chk("over_state", 32'(a_state), 3);
        chk("over_lives", 32'(a_lives), 0);
        chk("over_wr",    32'(a_wr), 0);

        new_view = 1'b1; fell = 1'b1; step(1);
        new_view = 1'b0; fell = 1'b0;
        chk("over_ign_state", 32'(a_state), 3);
        chk("over_ign_score", 32'(a_score), 20);
        chk("over_ign_lives", 32'(a_lives), 0);
        for (int i = 0; i < 4; i++) begin
            chk("over_no_tick", 32'({a_tick, b_tick}), 0);
            step(1);
        end

        start_btn = 1'b1; step(1);
        start_btn = 1'b0;
        chk("restart_state", 32'(a_state), 1);
        chk("restart_score", 32'(a_score), 0);
        chk("restart_lives", 32'(a_lives), 3);
        chk("restart_wr",    32'(a_wr), 1);
        new_view = 1'b1; step(1);
        new_view = 1'b0;
        chk("restart_view", 32'(a_score), 10);
        chk("restart_wr_off", 32'(a_wr), 0);

        reset = 1'b1; step(1);
        chk("midrst_state", 32'(a_state), 0);
        chk("midrst_score", 32'(a_score), 0);
        chk("midrst_lives", 32'(a_lives), 0);
        chk("midrst_tick",  32'({a_tick, b_tick}), 0);
        chk("midrst_wr",    32'(a_wr), 0);
        chk("midrst_move",  32'({a_ml, a_mr}), 0);
        reset = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
